// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store front end:
// funct3 codes, FSM state encoding and size/mask helpers.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CLR  = 2'd2
    } state_t;

    // Byte count minus one for the access size in funct3[1:0].
    function automatic logic [2:0] f3_bytes(input logic [1:0] sz);
        logic [3:0] n;
        n = (4'd1 << sz) - 4'd1;
        return n[2:0];
    endfunction

    // Zero every store byte above the access size.
    function automatic logic [63:0] store_mask(input logic [1:0] sz,
                                               input logic [63:0] d);
        logic [63:0] r;
        unique case (sz)
            2'd0:    r = {56'd0, d[7:0]};
            2'd1:    r = {48'd0, d[15:0]};
            2'd2:    r = {32'd0, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load data extension: sign/zero extends raw cache data per funct3.
// Ports: funct3 (load type), raw (cache data), ext (extended result).
module mem_load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [63:0] raw,
    output logic [63:0] ext
);

    always_comb begin
        ext = raw;
        unique case (funct3)
            F3_LB:   ext = {{56{raw[7]}}, raw[7:0]};
            F3_LH:   ext = {{48{raw[15]}}, raw[15:0]};
            F3_LW:   ext = {{32{raw[31]}}, raw[31:0]};
            F3_LBU:  ext = {56'd0, raw[7:0]};
            F3_LHU:  ext = {48'd0, raw[15:0]};
            F3_LWU:  ext = {32'd0, raw[31:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end driving a four-phase req/ack cache core.
// Ports: clk/rst; i_start/i_ren/i_wen/i_funct3/i_addr/i_wdata request;
// o_ready/o_busy/o_done/o_rdata status; o_cache_core_* and i_cache_core_*
// form the cache core handshake.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [2:0]  i_funct3,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_wdata,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic [63:0] o_rdata,
    output logic [63:0] o_cache_core_addr,
    output logic [63:0] o_cache_core_wdata,
    output logic [2:0]  o_cache_core_bytes,
    output logic        o_cache_core_op,
    output logic        o_cache_core_req,
    input  logic [63:0] i_cache_core_rdata,
    input  logic        i_cache_core_ack
);

    state_t      state;
    state_t      state_nx;
    logic [2:0]  f3_q;
    logic [63:0] ext_data;
    logic [63:0] loads_done;
    logic [63:0] stores_done;
    logic        mem_op;
    logic        accept;
    logic        noop;
    logic        hit;

    assign mem_op = i_ren | i_wen;
    assign accept = i_start & o_ready & mem_op;
    assign noop   = i_start & o_ready & ~mem_op;
    assign hit    = (state == ST_REQ) & i_cache_core_ack;

    mem_load_ext u_ext (
        .funct3 (f3_q),
        .raw    (i_cache_core_rdata),
        .ext    (ext_data)
    );

    always_comb begin
        state_nx         = state;
        o_cache_core_req = 1'b0;
        o_ready          = 1'b0;
        // Busy drops in the done cycle so the pipeline can advance
        // while the cache core is still releasing ack.
        o_busy           = i_start & mem_op;
        unique case (state)
            ST_IDLE: begin
                o_ready = ~i_cache_core_ack;
                if (accept) state_nx = ST_REQ;
            end
            ST_REQ: begin
                o_cache_core_req = 1'b1;
                o_busy           = 1'b1;
                if (i_cache_core_ack) state_nx = ST_CLR;
            end
            ST_CLR: begin
                if (!i_cache_core_ack) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            o_done             <= 1'b0;
            o_rdata            <= '0;
            o_cache_core_addr  <= '0;
            o_cache_core_wdata <= '0;
            o_cache_core_bytes <= '0;
            o_cache_core_op    <= 1'b0;
            f3_q               <= '0;
            loads_done         <= '0;
            stores_done        <= '0;
        end else begin
            state  <= state_nx;
            o_done <= hit | noop;
            if (accept) begin
                o_cache_core_addr  <= i_addr;
                o_cache_core_op    <= i_wen;
                o_cache_core_bytes <= f3_bytes(i_funct3[1:0]);
                o_cache_core_wdata <= store_mask(i_funct3[1:0], i_wdata);
                f3_q               <= i_funct3;
            end
            if (hit && !o_cache_core_op) o_rdata <= ext_data;
            if (hit) begin
                if (o_cache_core_op) stores_done <= stores_done + 64'd1;
                else                 loads_done  <= loads_done + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a delayed-ack cache model
// and a scoreboard of expected cache-side and result values.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_ren, i_wen;
    logic [2:0]  i_funct3;
    logic [63:0] i_addr, i_wdata;
    logic        o_ready, o_busy, o_done;
    logic [63:0] o_rdata;
    logic [63:0] o_cache_core_addr, o_cache_core_wdata;
    logic [2:0]  o_cache_core_bytes;
    logic        o_cache_core_op, o_cache_core_req;
    logic [63:0] i_cache_core_rdata;
    logic        i_cache_core_ack;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  bytes;
        logic        op;
        logic [63:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          ack_delay = 1;
    int          cnt = 0;
    int          req_cycles;
    logic [63:0] exp_rdata = '0;
    logic [63:0] exp_loads = '0;
    logic [63:0] exp_stores = '0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk                (clk),
        .rst                (rst),
        .i_start            (i_start),
        .i_ren              (i_ren),
        .i_wen              (i_wen),
        .i_funct3           (i_funct3),
        .i_addr             (i_addr),
        .i_wdata            (i_wdata),
        .o_ready            (o_ready),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_rdata            (o_rdata),
        .o_cache_core_addr  (o_cache_core_addr),
        .o_cache_core_wdata (o_cache_core_wdata),
        .o_cache_core_bytes (o_cache_core_bytes),
        .o_cache_core_op    (o_cache_core_op),
        .o_cache_core_req   (o_cache_core_req),
        .i_cache_core_rdata (i_cache_core_rdata),
        .i_cache_core_ack   (i_cache_core_ack)
    );

    // Cache core: raises ack after ack_delay cycles of req, drops it
    // one cycle after req falls.
    always @(posedge clk) begin
        if (rst || !o_cache_core_req) begin
            i_cache_core_ack <= 1'b0;
            cnt <= 0;
        end else begin
            if (cnt + 1 >= ack_delay) i_cache_core_ack <= 1'b1;
            cnt <= cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_ext(input logic [2:0] f,
                                          input logic [63:0] d);
        case (f)
            3'd0: return 64'($signed(d[7:0]));
            3'd1: return 64'($signed(d[15:0]));
            3'd2: return 64'($signed(d[31:0]));
            3'd4: return 64'(d[7:0]);
            3'd5: return 64'(d[15:0]);
            3'd6: return 64'(d[31:0]);
            default: return d;
        endcase
    endfunction

    function automatic logic [2:0] m_bytes(input logic [2:0] f);
        case (f[1:0])
            2'd0: return 3'd0;
            2'd1: return 3'd1;
            2'd2: return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] m_wmask(input logic [2:0] f,
                                            input logic [63:0] d);
        logic [63:0] m;
        m = '1;
        if (f[1:0] != 2'd3) m = (64'd1 << (8 << f[1:0])) - 64'd1;
        return d & m;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    // Issue one load/store, run it to o_done and check against the model.
    task automatic access(input logic wen, input logic [2:0] f,
                          input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] cd, input int dly);
        exp_t e;
        exp_t g;
        logic first;
        int   n;
        ack_delay = dly;
        i_cache_core_rdata = cd;
        wait_ready();
        e.addr  = a;
        e.op    = wen;
        e.bytes = m_bytes(f);
        e.wdata = m_wmask(f, wd);
        if (!wen) exp_rdata = m_ext(f, cd);
        e.rdata = exp_rdata;
        sb.push_back(e);
        i_start = 1'b1; i_ren = ~wen; i_wen = wen;
        i_funct3 = f; i_addr = a; i_wdata = wd;
        #1 chk("busy_at_start", 64'(o_busy), 64'd1);
        @(negedge clk);
        i_start = 1'b0; i_ren = 1'b0; i_wen = 1'b0;
        i_addr = '1; i_wdata = '1;
        chk("req_next_cycle", 64'(o_cache_core_req), 64'd1);
        first = 1'b1;
        req_cycles = 0;
        n = 0;
        while (!o_done && n < 200) begin
            if (o_cache_core_req) begin
                req_cycles++;
                if (first || o_cache_core_addr !== sb[0].addr)
                    chk("cc_addr", o_cache_core_addr, sb[0].addr);
                if (first) begin
                    chk("cc_bytes", 64'(o_cache_core_bytes),
                        64'(sb[0].bytes));
                    chk("cc_op", 64'(o_cache_core_op), 64'(sb[0].op));
                    if (sb[0].op)
                        chk("cc_wdata", o_cache_core_wdata, sb[0].wdata);
                end
                first = 1'b0;
            end
            if (!o_busy) chk("busy_hold", 64'(o_busy), 64'd1);
            @(negedge clk);
            n++;
        end
        if (!o_done) chk("done_timeout", 64'd0, 64'd1);
        g = sb.pop_front();
        chk("rdata", o_rdata, g.rdata);
        chk("req_low_at_done", 64'(o_cache_core_req), 64'd0);
        chk("busy_low_at_done", 64'(o_busy), 64'd0);
        if (wen) exp_stores++;
        else     exp_loads++;
        chk("loads_done", dut.loads_done, exp_loads);
        chk("stores_done", dut.stores_done, exp_stores);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        i_start = 0; i_ren = 0; i_wen = 0; i_funct3 = '0;
        i_addr = '0; i_wdata = '0; i_cache_core_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_req", 64'(o_cache_core_req), 64'd0);
        chk("rst_rdata", o_rdata, 64'd0);
        chk("rst_addr", o_cache_core_addr, 64'd0);
        chk("rst_wdata", o_cache_core_wdata, 64'd0);
        chk("rst_bytes", 64'(o_cache_core_bytes), 64'd0);
        chk("rst_op", 64'(o_cache_core_op), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        access(1'b0, 3'd0, 64'h8000_0003, 64'd0, 64'h80, 1);
        access(1'b0, 3'd4, 64'h8000_0003, 64'd0, 64'h80, 1);
        access(1'b1, 3'd2, 64'h8000_000E, 64'h1122_3344_5566_7788,
               64'hDEAD_BEEF_DEAD_BEEF, 1);
        access(1'b0, 3'd3, 64'h8000_0100, 64'd0,
               64'hFEDC_BA98_7654_3210, 10);
        chk("ld_req_cycles", 64'(req_cycles), 64'd11);
        access(1'b0, 3'd1, 64'h10, 64'd0, 64'h0000_0000_0000_8001, 2);
        access(1'b1, 3'd0, 64'h21, 64'hAAAA_BBBB_CCCC_DDEE, 64'd0, 3);

        // Start during CLR (ack still high) must be dropped.
        i_start = 1'b1; i_ren = 1'b1; i_funct3 = 3'd3; i_addr = 64'h40;
        #1 chk("ready_in_clr", 64'(o_ready), 64'd0);
        @(negedge clk);
        i_start = 1'b0; i_ren = 1'b0;
        seen = 0;
        repeat (5) begin
            if (o_cache_core_req || o_done) seen++;
            @(negedge clk);
        end
        chk("dropped_start", 64'(seen), 64'd0);
        access(1'b0, 3'd6, 64'h48, 64'd0, 64'h1234_5678_9ABC_DEF0, 1);

        // Start with neither ren nor wen: done next cycle, no access.
        wait_ready();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("noop_done", 64'(o_done), 64'd1);
        chk("noop_req", 64'(o_cache_core_req), 64'd0);
        chk("noop_rdata", o_rdata, exp_rdata);

        // Reset in the middle of a request.
        @(negedge clk);
        ack_delay = 10;
        i_start = 1'b1; i_ren = 1'b1; i_funct3 = 3'd3; i_addr = 64'h80;
        @(negedge clk);
        i_start = 1'b0; i_ren = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_req", 64'(o_cache_core_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_req", 64'(o_cache_core_req), 64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        chk("mid_rst_loads", dut.loads_done, 64'd0);
        chk("mid_rst_stores", dut.stores_done, 64'd0);
        exp_loads = '0; exp_stores = '0; exp_rdata = '0;
        seen = 0;
        repeat (12) begin
            if (o_done || o_cache_core_req) seen++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", 64'(seen), 64'd0);

        access(1'b0, 3'd2, 64'h8000_0000, 64'd0, 64'h8000_0001, 1);
        access(1'b0, 3'd6, 64'h8000_0000, 64'd0, 64'h8000_0001, 1);
        chk("final_loads", dut.loads_done, 64'd2);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
